rvv_backend_rs_mpush_fifo: RTL and testbench
============================================

// Module: rvv_backend_rs_mpush_fifo
// PURPOSE
//  Reservation-station FIFO at the receiving end of the dispatch->RS handshake (rs_valid_dp2*/rs_ready_*2dp).
//  Accepts up to NUM_PUSH uops per cycle from dispatch and buffers them in order.
//  Presents up to NUM_POP oldest uops to one execution unit (ALU/MUL/DIV/PMTRDT/LSU); one instance per unit.
// PARAMETERS
//  DWIDTH   default 128  width of one buffered uop (packed RS uop struct)
//  DEPTH    default 8    entries; power of 2, >= NUM_PUSH and >= NUM_POP
//  NUM_PUSH default `NUM_DP_UOP  push slots per cycle
//  NUM_POP  default 2    pop slots per cycle
// PORTS
//  clk         in  1                clock
//  rst_n       in  1                async active-low reset
//  trap_flush  in  1                synchronous flush of all entries
//  push_valid  in  NUM_PUSH         per-slot push request (from rs_valid_dp2*)
//  push_data   in  NUM_PUSH*DWIDTH  per-slot uop; slot 0 = oldest
//  push_ready  out NUM_PUSH         per-slot room (to rs_ready_*2dp)
//  pop_valid   out NUM_POP          pop_valid[j]=1 when >= j+1 entries are held
//  pop_data    out NUM_POP*DWIDTH   j-th oldest entry; slot 0 = head
//  pop_ready   in  NUM_POP          consumer takes slot j
//  fifo_full   out 1                count==DEPTH
//  fifo_empty  out 1                count==0
//  entry_cnt   out $clog2(DEPTH)+1  current occupancy
// BEHAVIOUR
//  - Reset (rst_n=0, async): rd/wr pointers=0, count=0; push_ready=all-1, pop_valid=0, fifo_empty=1, fifo_full=0,
//    entry_cnt=0. Storage not reset; pop_data is don't-care while pop_valid=0.
//  - Pointers carry an extra wrap bit (width $clog2(DEPTH)+1); index = low bits, wrap-around is modulo DEPTH.
//  - push_ready[i] = (DEPTH-count) > i; depends only on registered state, never on push_valid (dispatch gates valid with ready).
//  - push_valid is a prefix: valid[i] implies valid[i-1]. Push slot i when push_valid[i]&push_ready[i]; written at wr_ptr+i.
//  - Pop is a prefix: pop_ready[j] implies pop_ready[j-1] and pop_valid[j]. Violations are illegal (asserted in sim).
//  - npush/npop = popcount of accepted slots; next count = count + npush - npop; wr_ptr += npush; rd_ptr += npop.
//  - Latency: a pushed uop appears on pop_data/pop_valid on the next cycle; no same-cycle empty bypass.
//  - Full: push_ready=0; a simultaneous pop frees room only from the next cycle (unless the macro below is set).
//  - Empty: pop_valid=0; pop_ready ignored.
//  - Simultaneous push+pop: both applied in the same edge; count never exceeds DEPTH or drops below 0.
//  - trap_flush=1: next edge pointers and count -> 0; pushes and pops in that cycle are discarded. Outputs keep the
//    pre-flush state during the flush cycle.
//  - Reset mid-operation: all contents are lost immediately; no partial write survives.
// CONFIGURATION
//  RS_FIFO_POP_THRU_EN defined: push_ready[i] = (DEPTH-count+npop) > i. Same-cycle pops make room for pushes
//    (comb path pop_ready->push_ready). Storage write and read to the same entry in one cycle are legal.
//  Not defined: push_ready uses registered count only. No pop->push comb path.
// STRUCTURE
//  - Shared package/header (rvv_backend.svh): RS uop struct typedefs, `NUM_DP_UOP, per-unit RS depth constants.
//  - Sub-module rvv_backend_rs_ptr_ctrl: pointer/count update, npush/npop popcount, ready/valid generation.
//  - Top holds the storage array and the NUM_PUSH write / NUM_POP read muxes.
// TESTING (DEPTH=8, NUM_PUSH=2, NUM_POP=2)
//  - Reset: rst_n low mid-stream with count=5 -> count=0, pop_valid=00, push_ready=11 immediately.
//  - Fill: push 2/cycle for 4 cycles (A..H) -> count 2,4,6,8; fifo_full=1, push_ready=00; pop order A,B,C...
//  - Near-full: count=7 -> push_ready=01; push_valid=11 accepts only slot 0; count=8.
//  - Wrap: fill 8, pop 2x3, push 6 -> pointers wrap; pops return the remaining data in insertion order.
//  - Full + pop2 same cycle: without macro push_ready=00 that cycle, count=6 next; with RS_FIFO_POP_THRU_EN
//    push_ready=11, push 2, count stays 8.
//  - Flush: count=5, trap_flush with push_valid=11 and pop_ready=01 -> next cycle count=0, empty=1, nothing written.

Source files
------------

// File: rtl/rvv_backend_rs_mpush_fifo_pkg.sv
// Shared RS definitions: uop payload layout, dispatch width and per-unit RS depths.
package rvv_backend_rs_mpush_fifo_pkg;

  // Number of uops dispatch can hand to one RS per cycle.
  localparam int unsigned NUM_DP_UOP = 2;

  // Per-unit reservation-station depths.
  localparam int unsigned ALU_RS_DEPTH    = 8;
  localparam int unsigned MUL_RS_DEPTH    = 8;
  localparam int unsigned DIV_RS_DEPTH    = 4;
  localparam int unsigned PMTRDT_RS_DEPTH = 4;
  localparam int unsigned LSU_RS_DEPTH    = 8;

  // One buffered RS uop (128 bits).
  typedef struct packed {
    logic [7:0]  rob_entry;
    logic [7:0]  uop_type;
    logic [15:0] vreg_index;
    logic [31:0] rs1_data;
    logic [31:0] vcsr;
    logic [31:0] imm_pc;
  } rs_uop_t;

  localparam int unsigned RS_UOP_W = $bits(rs_uop_t);

endpackage

// File: rtl/rvv_backend_rs_mpush_fifo_if.sv
// Dispatch->RS push bus and RS->execution-unit pop bus.
//   push_valid/push_data/push_ready : NUM_PUSH slots, slot 0 = oldest
//   pop_valid/pop_data/pop_ready    : NUM_POP slots, slot 0 = head
// master = producer/consumer side, slave = the FIFO.
interface rvv_backend_rs_mpush_fifo_if #(
  parameter int unsigned DWIDTH   = 128,
  parameter int unsigned NUM_PUSH = 2,
  parameter int unsigned NUM_POP  = 2
);
  logic [NUM_PUSH-1:0]        push_valid;
  logic [NUM_PUSH*DWIDTH-1:0] push_data;
  logic [NUM_PUSH-1:0]        push_ready;
  logic [NUM_POP-1:0]         pop_valid;
  logic [NUM_POP*DWIDTH-1:0]  pop_data;
  logic [NUM_POP-1:0]         pop_ready;

  modport master (
    output push_valid, push_data, pop_ready,
    input  push_ready, pop_valid, pop_data
  );

  modport slave (
    input  push_valid, push_data, pop_ready,
    output push_ready, pop_valid, pop_data
  );
endinterface

// File: rtl/rvv_backend_rs_mpush_fifo_ptr_ctrl.sv
// Pointer/occupancy control for the multi-push RS FIFO: counts accepted
// push/pop slots, advances wrap-bit pointers and produces ready/valid/flags.
// Ports:
//   clk, rst_n       clock, async active-low reset
//   trap_flush_i     drop all entries at the next edge
//   push_valid_i     per-slot push request (prefix)
//   push_ready_o     per-slot room
//   push_en_o        per-slot storage write enable
//   pop_ready_i      per-slot consumer take (prefix)
//   pop_valid_o      per-slot entry present
//   wr_ptr_o/rd_ptr_o pointers with wrap bit
//   entry_cnt_o, full_o, empty_o occupancy
// Option: RS_FIFO_POP_THRU_EN lets same-cycle pops create push room.
module rvv_backend_rs_mpush_fifo_ptr_ctrl #(
  parameter int unsigned DEPTH    = 8,
  parameter int unsigned NUM_PUSH = 2,
  parameter int unsigned NUM_POP  = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    trap_flush_i,
  input  logic [NUM_PUSH-1:0]     push_valid_i,
  output logic [NUM_PUSH-1:0]     push_ready_o,
  output logic [NUM_PUSH-1:0]     push_en_o,
  input  logic [NUM_POP-1:0]      pop_ready_i,
  output logic [NUM_POP-1:0]      pop_valid_o,
  output logic [$clog2(DEPTH):0]  wr_ptr_o,
  output logic [$clog2(DEPTH):0]  rd_ptr_o,
  output logic [$clog2(DEPTH):0]  entry_cnt_o,
  output logic                    full_o,
  output logic                    empty_o
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;
  localparam int unsigned RW = PW + 1;

  logic [PW-1:0]       cnt_q, cnt_d;
  logic [PW-1:0]       wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]       rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]       free_q, free_d;
  logic [NUM_POP-1:0]  pop_vld_q, pop_vld_d;
  logic                full_q, full_d;
  logic                empty_q, empty_d;

  logic [NUM_PUSH-1:0] push_rdy, push_acc;
  logic [NUM_POP-1:0]  pop_acc;
  logic [PW-1:0]       npush, npop;
  logic [RW-1:0]       avail;

  // Accept counting, pointer/count update and next-state flags.
  always_comb begin
    pop_acc  = pop_ready_i & pop_vld_q;
    npop     = '0;
    for (int unsigned j = 0; j < NUM_POP; j++) npop = npop + PW'(pop_acc[j]);

`ifdef RS_FIFO_POP_THRU_EN
    // Entries leaving this cycle make room for entries arriving this cycle.
    avail = RW'(free_q) + RW'(npop);
`else
    avail = RW'(free_q);
`endif
    for (int unsigned i = 0; i < NUM_PUSH; i++) push_rdy[i] = avail > RW'(i);

    push_acc = push_valid_i & push_rdy;
    npush    = '0;
    for (int unsigned i = 0; i < NUM_PUSH; i++) npush = npush + PW'(push_acc[i]);

    cnt_d    = cnt_q + npush - npop;
    wr_ptr_d = wr_ptr_q + npush;
    rd_ptr_d = rd_ptr_q + npop;
    if (trap_flush_i) begin
      cnt_d    = '0;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end

    free_d  = PW'(DEPTH) - cnt_d;
    for (int unsigned j = 0; j < NUM_POP; j++) pop_vld_d[j] = cnt_d > PW'(j);
    full_d  = cnt_d == PW'(DEPTH);
    empty_d = cnt_d == '0;
  end

  // Occupancy state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q     <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      free_q    <= PW'(DEPTH);
      pop_vld_q <= '0;
      full_q    <= 1'b0;
      empty_q   <= 1'b1;
    end else begin
      cnt_q     <= cnt_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      free_q    <= free_d;
      pop_vld_q <= pop_vld_d;
      full_q    <= full_d;
      empty_q   <= empty_d;
    end
  end

  assign push_ready_o = push_rdy;
  assign push_en_o    = trap_flush_i ? '0 : push_acc;
  assign pop_valid_o  = pop_vld_q;
  assign wr_ptr_o     = wr_ptr_q;
  assign rd_ptr_o     = rd_ptr_q;
  assign entry_cnt_o  = cnt_q;
  assign full_o       = full_q;
  assign empty_o      = empty_q;

  // A prefix vector v has no set bit directly above a clear one: v & (v+1) == 0.
  logic [NUM_PUSH-1:0] push_gap;
  logic [NUM_POP-1:0]  pop_gap;
  assign push_gap = push_valid_i & (push_valid_i + NUM_PUSH'(1));
  assign pop_gap  = pop_ready_i & (pop_ready_i + NUM_POP'(1));

  a_push_prefix: assert property (@(posedge clk) disable iff (!rst_n) push_gap == '0);
  a_pop_prefix:  assert property (@(posedge clk) disable iff (!rst_n) pop_gap == '0);
  a_pop_held:    assert property (@(posedge clk) disable iff (!rst_n) (pop_ready_i & ~pop_vld_q) == '0);

endmodule

// File: rtl/rvv_backend_rs_mpush_fifo.sv
// Reservation-station FIFO: accepts up to NUM_PUSH uops/cycle from dispatch,
// presents the NUM_POP oldest uops to one execution unit.
// Ports:
//   clk, rst_n    clock, async active-low reset
//   trap_flush    drop all entries at the next edge
//   fifo_if       slave side of push/pop buses (push_valid/data/ready, pop_valid/data/ready)
//   fifo_full     count == DEPTH
//   fifo_empty    count == 0
//   entry_cnt     occupancy
// Option: define RS_FIFO_POP_THRU_EN to let same-cycle pops free push room.
module rvv_backend_rs_mpush_fifo
  import rvv_backend_rs_mpush_fifo_pkg::*;
#(
  parameter int unsigned DWIDTH   = RS_UOP_W,
  parameter int unsigned DEPTH    = 8,
  parameter int unsigned NUM_PUSH = NUM_DP_UOP,
  parameter int unsigned NUM_POP  = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     trap_flush,
  rvv_backend_rs_mpush_fifo_if.slave fifo_if,
  output logic                     fifo_full,
  output logic                     fifo_empty,
  output logic [$clog2(DEPTH):0]   entry_cnt
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;

  logic [NUM_PUSH-1:0]       push_en;
  logic [NUM_PUSH-1:0]       push_ready;
  logic [NUM_POP-1:0]        pop_valid;
  logic [PW-1:0]             wr_ptr, rd_ptr;
  logic [AW-1:0]             wr_idx [NUM_PUSH];
  logic [AW-1:0]             rd_idx [NUM_POP];
  logic [DWIDTH-1:0]         mem_q  [DEPTH];
  logic [NUM_POP*DWIDTH-1:0] pop_data;

  rvv_backend_rs_mpush_fifo_ptr_ctrl #(
    .DEPTH    (DEPTH),
    .NUM_PUSH (NUM_PUSH),
    .NUM_POP  (NUM_POP)
  ) u_ptr_ctrl (
    .clk          (clk),
    .rst_n        (rst_n),
    .trap_flush_i (trap_flush),
    .push_valid_i (fifo_if.push_valid),
    .push_ready_o (push_ready),
    .push_en_o    (push_en),
    .pop_ready_i  (fifo_if.pop_ready),
    .pop_valid_o  (pop_valid),
    .wr_ptr_o     (wr_ptr),
    .rd_ptr_o     (rd_ptr),
    .entry_cnt_o  (entry_cnt),
    .full_o       (fifo_full),
    .empty_o      (fifo_empty)
  );

  // Slot addresses: low pointer bits wrap modulo DEPTH.
  always_comb begin
    for (int unsigned i = 0; i < NUM_PUSH; i++) wr_idx[i] = AW'(wr_ptr + PW'(i));
    for (int unsigned j = 0; j < NUM_POP; j++)  rd_idx[j] = AW'(rd_ptr + PW'(j));
  end

  // Storage is intentionally not reset; pop_valid qualifies every read.
  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < NUM_PUSH; i++)
      if (push_en[i]) mem_q[wr_idx[i]] <= fifo_if.push_data[i*DWIDTH +: DWIDTH];
  end

  // Read mux: j-th oldest entry on pop slot j.
  always_comb begin
    pop_data = '0;
    for (int unsigned j = 0; j < NUM_POP; j++) pop_data[j*DWIDTH +: DWIDTH] = mem_q[rd_idx[j]];
  end

  assign fifo_if.push_ready = push_ready;
  assign fifo_if.pop_valid  = pop_valid;
  assign fifo_if.pop_data   = pop_data;

endmodule

// File: tb/tb_rvv_backend_rs_mpush_fifo.sv
// Directed bench for rvv_backend_rs_mpush_fifo (DEPTH=8, 2 push, 2 pop slots).
// Accepted pushes are queued as expected pop data; a negedge monitor compares
// every consumed pop slot against the queue head.
module tb_rvv_backend_rs_mpush_fifo;
  localparam int unsigned DW    = 16;
  localparam int unsigned DEPTH = 8;
  localparam int unsigned NPUSH = 2;
  localparam int unsigned NPOP  = 2;
  localparam int unsigned CW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          trap_flush = 1'b0;
  logic          fifo_full, fifo_empty;
  logic [CW-1:0] entry_cnt;

  int n_checks = 0;
  int n_fail   = 0;
  logic [DW-1:0] exp_q[$];

  rvv_backend_rs_mpush_fifo_if #(.DWIDTH(DW), .NUM_PUSH(NPUSH), .NUM_POP(NPOP)) fif ();

  rvv_backend_rs_mpush_fifo #(
    .DWIDTH(DW), .DEPTH(DEPTH), .NUM_PUSH(NPUSH), .NUM_POP(NPOP)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .trap_flush (trap_flush),
    .fifo_if    (fif),
    .fifo_full  (fifo_full),
    .fifo_empty (fifo_empty),
    .entry_cnt  (entry_cnt)
  );

  always #5 clk = ~clk;

  // Monitor: every consumed pop slot must match the oldest expected uop.
  always @(negedge clk) begin
    if (rst_n && !trap_flush) begin
      for (int j = 0; j < NPOP; j++) begin
        if (fif.pop_valid[j] && fif.pop_ready[j]) begin
          logic [DW-1:0] got, want;
          got = fif.pop_data[j*DW +: DW];
          n_checks++;
          if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL pop_data[%0d]: got %h, expected no entry", j, got);
          end else begin
            want = exp_q.pop_front();
            if (got !== want) begin
              n_fail++;
              $display("FAIL pop_data[%0d]: got %h, expected %h", j, got, want);
            end
          end
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [1:0] pv, input logic [DW-1:0] d0, input logic [DW-1:0] d1,
                       input logic [1:0] pr, input logic fl);
    fif.push_valid = pv;
    fif.push_data  = {d1, d0};
    fif.pop_ready  = pr;
    trap_flush     = fl;
    #1;
  endtask

  task automatic idle();
    drive(2'b00, '0, '0, 2'b00, 1'b0);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    n_checks++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, want);
    end
  endtask

  task automatic push2(input logic [DW-1:0] d0, input logic [DW-1:0] d1);
    drive(2'b11, d0, d1, 2'b00, 1'b0);
    exp_q.push_back(d0);
    exp_q.push_back(d1);
    step();
  endtask

  task automatic pop_cycles(input int n);
    for (int k = 0; k < n; k++) begin
      drive(2'b00, '0, '0, 2'b11, 1'b0);
      step();
    end
    idle();
  endtask

  initial begin
    fif.push_valid = '0;
    fif.push_data  = '0;
    fif.pop_ready  = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_cnt", 32'(entry_cnt), 0);
    chk("rst_empty", 32'(fifo_empty), 1);
    chk("rst_full", 32'(fifo_full), 0);
    chk("rst_push_ready", 32'(fif.push_ready), 3);
    chk("rst_pop_valid", 32'(fif.pop_valid), 0);
    rst_n = 1'b1;
    step();

    // Fill A..H two per cycle.
    for (int k = 0; k < 4; k++) begin
      drive(2'b11, DW'(16'hA0 + 2*k), DW'(16'hA1 + 2*k), 2'b00, 1'b0);
      chk("fill_push_ready", 32'(fif.push_ready), 3);
      exp_q.push_back(DW'(16'hA0 + 2*k));
      exp_q.push_back(DW'(16'hA1 + 2*k));
      step();
      chk("fill_cnt", 32'(entry_cnt), 32'(2*(k+1)));
    end
    idle();
    chk("fill_full", 32'(fifo_full), 1);
    chk("fill_push_ready_full", 32'(fif.push_ready), 0);
    chk("fill_pop_valid", 32'(fif.pop_valid), 3);
    drive(2'b00, '0, '0, 2'b11, 1'b0);
    step();
    drive(2'b00, '0, '0, 2'b01, 1'b0);
    step();
    idle();
    chk("pop3_cnt", 32'(entry_cnt), 5);

    // Asynchronous reset mid-stream.
    rst_n = 1'b0;
    #1;
    chk("async_rst_cnt", 32'(entry_cnt), 0);
    chk("async_rst_pop_valid", 32'(fif.pop_valid), 0);
    chk("async_rst_push_ready", 32'(fif.push_ready), 3);
    chk("async_rst_empty", 32'(fifo_empty), 1);
    exp_q.delete();
    step();
    rst_n = 1'b1;
    step();

    // Near-full: count 7 leaves room for slot 0 only.
    push2(16'h10, 16'h11);
    push2(16'h12, 16'h13);
    push2(16'h14, 16'h15);
    drive(2'b01, 16'h16, 16'h0, 2'b00, 1'b0);
    exp_q.push_back(16'h16);
    step();
    idle();
    chk("nf_cnt7", 32'(entry_cnt), 7);
    chk("nf_push_ready", 32'(fif.push_ready), 1);
    drive(2'b11, 16'h17, 16'h18, 2'b00, 1'b0);
    chk("nf_push_ready_driven", 32'(fif.push_ready), 1);
    exp_q.push_back(16'h17);
    step();
    idle();
    chk("nf_cnt8", 32'(entry_cnt), 8);
    chk("nf_full", 32'(fifo_full), 1);
    pop_cycles(4);
    chk("nf_empty", 32'(fifo_empty), 1);

    // Wrap: fill 8, pop 6, push 6, drain.
    push2(16'h20, 16'h21);
    push2(16'h22, 16'h23);
    push2(16'h24, 16'h25);
    push2(16'h26, 16'h27);
    pop_cycles(3);
    chk("wrap_cnt2", 32'(entry_cnt), 2);
    push2(16'h28, 16'h29);
    push2(16'h2A, 16'h2B);
    push2(16'h2C, 16'h2D);
    idle();
    chk("wrap_cnt8", 32'(entry_cnt), 8);
    pop_cycles(4);
    chk("wrap_empty", 32'(fifo_empty), 1);

    // Full with two pops and two pushes offered in the same cycle.
    push2(16'h30, 16'h31);
    push2(16'h32, 16'h33);
    push2(16'h34, 16'h35);
    push2(16'h36, 16'h37);
    drive(2'b11, 16'h38, 16'h39, 2'b11, 1'b0);
`ifdef RS_FIFO_POP_THRU_EN
    chk("fullpop_push_ready", 32'(fif.push_ready), 3);
    exp_q.push_back(16'h38);
    exp_q.push_back(16'h39);
    step();
    idle();
    chk("fullpop_cnt", 32'(entry_cnt), 8);
    pop_cycles(4);
`else
    chk("fullpop_push_ready", 32'(fif.push_ready), 0);
    step();
    idle();
    chk("fullpop_cnt", 32'(entry_cnt), 6);
    pop_cycles(3);
`endif
    chk("fullpop_empty", 32'(fifo_empty), 1);

    // Flush at count 5 with a push and a pop offered.
    push2(16'h40, 16'h41);
    push2(16'h42, 16'h43);
    drive(2'b01, 16'h44, 16'h0, 2'b00, 1'b0);
    exp_q.push_back(16'h44);
    step();
    idle();
    chk("flush_pre_cnt", 32'(entry_cnt), 5);
    drive(2'b11, 16'h45, 16'h46, 2'b01, 1'b1);
    chk("flush_cycle_cnt", 32'(entry_cnt), 5);
    chk("flush_cycle_pop_valid", 32'(fif.pop_valid), 3);
    step();
    exp_q.delete();
    idle();
    chk("flush_cnt", 32'(entry_cnt), 0);
    chk("flush_empty", 32'(fifo_empty), 1);
    chk("flush_pop_valid", 32'(fif.pop_valid), 0);
    chk("flush_push_ready", 32'(fif.push_ready), 3);
    push2(16'h50, 16'h51);
    pop_cycles(1);
    chk("post_flush_empty", 32'(fifo_empty), 1);

    // Simultaneous push and pop at count 2.
    push2(16'h60, 16'h61);
    drive(2'b11, 16'h62, 16'h63, 2'b11, 1'b0);
    exp_q.push_back(16'h62);
    exp_q.push_back(16'h63);
    step();
    idle();
    chk("pushpop_cnt", 32'(entry_cnt), 2);
    pop_cycles(1);
    chk("pushpop_empty", 32'(fifo_empty), 1);
    chk("scoreboard_drained", 32'(exp_q.size()), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
